pulse_sync_rx: RTL and testbench
================================

PULSE_SYNC_RX -- requirements
Module: pulse_sync_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on req_async; legal range 2..4.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of event_count.
REQ-003 fast_clk  input  1  SHALL be the single clock; all flops clock on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_async  input  1  SHALL be the 4-phase request level from the slow domain, asynchronous to fast_clk.
REQ-006 hold  input  1  SHALL be consumer backpressure: while 1, no pulse is issued and the request stays pending.
REQ-007 clr_count  input  1  SHALL be a synchronous clear of event_count and err.
REQ-008 ack_out  output  1  SHALL be the 4-phase acknowledge returned to the slow domain; driven directly from a flop.
REQ-009 pulse_out  output  1  SHALL be a one-fast_clk-cycle strobe per accepted request; driven directly from a flop.
REQ-010 busy  output  1  SHALL be 1 in every state except IDLE.
REQ-011 event_count  output  CNT_W  SHALL be the number of pulses issued, saturating.
REQ-012 err  output  1  SHALL be a sticky flag for a request withdrawn before acknowledge.

Function
REQ-013 req_async SHALL pass through SYNC_STAGES flops; req_s is the last stage; no other logic reads req_async.
REQ-014 The FSM SHALL have exactly four states: IDLE, PEND, PULSE, ACK.
REQ-015 IDLE: req_s=1 and hold=0 -> PULSE; req_s=1 and hold=1 -> PEND; else stay.
REQ-016 PEND: req_s=0 -> IDLE and set err; else hold=0 -> PULSE; else stay.
REQ-017 PULSE SHALL last exactly one cycle, then -> ACK unconditionally; hold is ignored in PULSE.
REQ-018 ACK: req_s=0 -> IDLE; else stay.
REQ-019 pulse_out SHALL be 1 exactly in the cycles the FSM is in PULSE; ack_out SHALL be 1 exactly in the cycles the FSM is in ACK.
REQ-020 Latency: req_async rises before edge 1 with hold=0 -> req_s=1 after edge SYNC_STAGES, PULSE entered at edge SYNC_STAGES+1, ack_out=1 from edge SYNC_STAGES+2.
REQ-021 ack_out SHALL fall at the edge after req_s is first seen 0 in ACK, i.e. SYNC_STAGES+1 edges after req_async falls.
REQ-022 A new request SHALL only be accepted after ack_out has returned to 0 (return-to-zero complete); exactly one pulse per 4-phase cycle.
REQ-023 req_async pulses shorter than one fast_clk period are not guaranteed to be seen; a request held until ack_out=1 SHALL always yield exactly one pulse.
REQ-024 event_count SHALL increment by 1 on each PULSE cycle and saturate at 2^CNT_W-1 with no wrap.
REQ-025 clr_count=1 SHALL zero event_count and err at the next edge; if PULSE occurs in the same cycle, event_count becomes 1.
REQ-026 If clr_count=1 in the same cycle err would be set (PEND withdraw), err SHALL end 1 (set wins).
REQ-027 err SHALL not affect FSM operation.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear the sync flops, the FSM to IDLE, and ack_out, pulse_out, busy, event_count, and err to 0.
REQ-029 Reset mid-handshake SHALL drop ack_out immediately with no pulse issued; if req_async is still 1 after release, it SHALL be treated as a new request (pulse after SYNC_STAGES+1 edges).
REQ-030 Reset release SHALL be used synchronously to fast_clk by the instantiating level; the block SHALL not add its own reset synchronizer.

Verification
REQ-031 Basic, SYNC_STAGES=2, hold=0: req_async 0->1 before edge 1 -> pulse_out=1 in cycle 3 only, ack_out=1 from edge 4; req_async 1->0 -> ack_out=0 three edges later; event_count=1.
REQ-032 Backpressure: hold=1 before request, released 5 cycles after busy rises -> no pulse while hold=1; a single pulse on the cycle after hold falls; count +1.
REQ-033 Withdraw: hold=1, req high then low with no ack -> FSM IDLE, pulse_out never 1, err=1, event_count unchanged; clr_count -> err=0.
REQ-034 Saturation, CNT_W=2: 5 full handshakes -> event_count 1,2,3,3,3; clr_count coincident with 6th pulse -> event_count=1.
REQ-035 Reset mid-ACK: reset_n low while ack_out=1 and req_async held 1 -> ack_out=0 immediately; after release, one new pulse at edge 3 and ack_out at edge 4.
REQ-036 Back-to-back: 20 random-gap 4-phase handshakes driven from a slow_clk model -> exactly 20 pulses, each of width 1, and pulse_out never asserted while ack_out=1.

Source files
------------

// File: rtl/pulse_sync_rx.sv
// Receive side of a 4-phase req/ack crossing: synchronizes req_async, issues one
// fast_clk strobe per request (with consumer backpressure) and counts the strobes.
module pulse_sync_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             fast_clk,
  input  logic             reset_n,
  input  logic             req_async,
  input  logic             hold,
  input  logic             clr_count,
  output logic             ack_out,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] event_count,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    PULSE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   set_err;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
    end
  end

  always_comb begin
    state_nxt = state_q;
    set_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) state_nxt = hold ? PEND : PULSE;
      end
      PEND: begin
        if (!req_s) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end else if (!hold) begin
          state_nxt = PULSE;
        end
      end
      PULSE: state_nxt = ACK;
      ACK: begin
        if (!req_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pulse_out <= 1'b0;
      ack_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pulse_out <= (state_nxt == PULSE);
      ack_out   <= (state_nxt == ACK);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Count on the edge closing each PULSE cycle; a coincident clear leaves one event.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      event_count <= '0;
    end else if (state_q == PULSE) begin
      if (clr_count) begin
        event_count <= CNT_W'(1);
      end else if (event_count != '1) begin
        event_count <= event_count + 1'b1;
      end
    end else if (clr_count) begin
      event_count <= '0;
    end
  end

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (set_err) begin
      err <= 1'b1;
    end else if (clr_count) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Directed bench for pulse_sync_rx (SYNC_STAGES=2, CNT_W=2) with a slow-clock
// handshake model for the back-to-back scenario.
module tb_pulse_sync_rx;

  logic       fast_clk = 1'b0;
  logic       slow_clk = 1'b0;
  logic       reset_n;
  logic       req_async;
  logic       hold;
  logic       clr_count;
  logic       ack_out;
  logic       pulse_out;
  logic       busy;
  logic [1:0] event_count;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic mon_en       = 1'b0;
  logic mon_prev     = 1'b0;
  int   mon_pulses   = 0;
  int   mon_wide     = 0;
  int   mon_overlap  = 0;

  pulse_sync_rx #(.SYNC_STAGES(2), .CNT_W(2)) dut (
    .fast_clk    (fast_clk),
    .reset_n     (reset_n),
    .req_async   (req_async),
    .hold        (hold),
    .clr_count   (clr_count),
    .ack_out     (ack_out),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .event_count (event_count),
    .err         (err)
  );

  always #5 fast_clk = ~fast_clk;
  always #18 slow_clk = ~slow_clk;

  always @(negedge fast_clk) begin
    if (mon_en) begin
      if (pulse_out) mon_pulses++;
      if (pulse_out && mon_prev) mon_wide++;
      if (pulse_out && ack_out) mon_overlap++;
    end
    mon_prev <= pulse_out;
  end

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_async = 1'b0; hold = 1'b0; clr_count = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({ack_out, pulse_out, busy, event_count, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 000000", {ack_out, pulse_out, busy, event_count, err});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    req_async = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp++;
      if (pulse_out !== (e == 3)) begin
        n_fail++;
        $display("FAIL basic_pulse edge %0d got %b want %b", e, pulse_out, (e == 3));
      end
      n_cmp++;
      if (ack_out !== (e == 4)) begin
        n_fail++;
        $display("FAIL basic_ack edge %0d got %b want %b", e, ack_out, (e == 4));
      end
    end
    req_async = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if (ack_out !== (e < 3)) begin
        n_fail++;
        $display("FAIL basic_ack_fall edge %0d got %b want %b", e, ack_out, (e < 3));
      end
    end
    n_cmp++;
    if (event_count !== 2'd1) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 1", event_count);
    end
  endtask

  task automatic test_backpressure();
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    hold = 1'b1;
    req_async = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if (busy !== (e == 3) || pulse_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_enter edge %0d busy/pulse got %b%b want %b0", e, busy, pulse_out, (e == 3));
      end
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (pulse_out !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d busy/pulse got %b%b want 10", c, busy, pulse_out);
      end
    end
    hold = 1'b0;
    tick();
    n_cmp++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_pulse got %b want 1", pulse_out);
    end
    tick();
    n_cmp++;
    if (pulse_out !== 1'b0 || ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_after pulse/ack got %b%b want 01", pulse_out, ack_out);
    end
    req_async = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (event_count !== 2'd1 || ack_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count count/ack got %0d/%b want 1/0", event_count, ack_out);
    end
  endtask

  task automatic test_withdraw();
    logic saw_pulse;
    // plain withdraw
    saw_pulse = 1'b0;
    hold = 1'b1;
    req_async = 1'b1;
    tick(); tick(); tick();
    saw_pulse |= pulse_out;
    req_async = 1'b0;
    tick(); saw_pulse |= pulse_out;
    tick(); saw_pulse |= pulse_out;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_err_early got %b want 0", err);
    end
    tick(); saw_pulse |= pulse_out;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || saw_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_result err/busy/pulse got %b%b%b want 100", err, busy, saw_pulse);
    end
    n_cmp++;
    if (event_count !== 2'd1) begin
      n_fail++;
      $display("FAIL wd_count got %0d want 1", event_count);
    end
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || event_count !== 2'd0) begin
      n_fail++;
      $display("FAIL wd_clear err/count got %b/%0d want 0/0", err, event_count);
    end
    // withdraw with clear held throughout: set wins
    req_async = 1'b1;
    tick(); tick(); tick();
    req_async = 1'b0;
    clr_count = 1'b1;
    tick(); tick(); tick();
    clr_count = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_set_wins err/busy got %b%b want 10", err, busy);
    end
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_async = 1'b1;
      tick(); tick(); tick(); tick();
      req_async = 1'b0;
      tick(); tick(); tick();
      want = (i < 3) ? 2'(i + 1) : 2'd3;
      n_cmp++;
      if (event_count !== want) begin
        n_fail++;
        $display("FAIL sat_count hs %0d got %0d want %0d", i + 1, event_count, want);
      end
    end
    req_async = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pulse6 got %b want 1", pulse_out);
    end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    n_cmp++;
    if (event_count !== 2'd1) begin
      n_fail++;
      $display("FAIL sat_clr_with_pulse got %0d want 1", event_count);
    end
    req_async = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_ack();
    req_async = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_ack got %b want 1", ack_out);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack_out, pulse_out, busy, event_count, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_immediate got %b want 000000", {ack_out, pulse_out, busy, event_count, err});
    end
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp++;
      if (pulse_out !== (e == 3) || ack_out !== (e == 4)) begin
        n_fail++;
        $display("FAIL rst_new_req edge %0d pulse/ack got %b%b want %b%b", e, pulse_out, ack_out, (e == 3), (e == 4));
      end
    end
    req_async = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    int budget;
    logic timed_out;
    timed_out = 1'b0;
    @(negedge fast_clk);
    mon_en = 1'b1;
    for (int h = 0; h < 20 && !timed_out; h++) begin
      repeat ($urandom_range(0, 3)) @(posedge slow_clk);
      @(posedge slow_clk);
      req_async = 1'b1;
      budget = 0;
      while (ack_out !== 1'b1 && budget < 50) begin
        @(posedge fast_clk); budget++;
      end
      if (ack_out !== 1'b1) timed_out = 1'b1;
      @(posedge slow_clk);
      req_async = 1'b0;
      budget = 0;
      while (ack_out !== 1'b0 && budget < 50) begin
        @(posedge fast_clk); budget++;
      end
      if (ack_out !== 1'b0) timed_out = 1'b1;
    end
    repeat (4) @(posedge fast_clk);
    @(negedge fast_clk);
    mon_en = 1'b0;
    n_cmp++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL b2b_timeout ack handshake got timeout want completion");
    end
    n_cmp++;
    if (mon_pulses !== 20) begin
      n_fail++;
      $display("FAIL b2b_pulses got %0d want 20", mon_pulses);
    end
    n_cmp++;
    if (mon_wide !== 0 || mon_overlap !== 0) begin
      n_fail++;
      $display("FAIL b2b_shape wide/overlap got %0d/%0d want 0/0", mon_wide, mon_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_withdraw();
    test_saturation();
    test_reset_mid_ack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
